// File: rtl/biu_pkg.sv
// Shared types and constants for the AXI-Lite bus interface unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package biu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR_ADDR,
    ST_WR_RESP,
    ST_RESP
  } biu_state_e;

  localparam logic [2:0] EXC_NONE    = 3'd0;
  localparam logic [2:0] EXC_BUS     = 3'd5;
  localparam logic [2:0] EXC_TIMEOUT = 3'd6;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Any non-OKAY AXI response is reported to the pipeline as a bus error.
  function automatic logic [2:0] resp_to_exc(input logic [1:0] resp);
    return (resp == RESP_OKAY) ? EXC_NONE : EXC_BUS;
  endfunction

endpackage

// File: rtl/biu_timeout.sv
// Saturating watchdog counter for one outstanding bus transaction.
// Latency: expire is combinational from the count; it asserts in the cycle whose increment reaches LIMIT-1.
// Backpressure: none; clr restarts the count, en advances it, count saturates at LIMIT-1.
//
// Ports: clk, rstn (async active-low), clr (restart at 0), en (count this cycle),
//        expire (this cycle is the last one before the limit).
module biu_timeout #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int            CW   = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
  localparam logic [CW-1:0] PRE  = CW'(LIMIT - 2);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  // Fires on the cycle whose increment would land on LIMIT-1, so the
  // owner leaves its wait state exactly when the counter reaches the limit.
  assign expire = en && (count == PRE);

endmodule

// File: rtl/axi_lite_biu.sv
// Single-outstanding AXI-Lite master bridging the core request port to the MMU-facing bus.
// Latency: accept at edge 0, address valid in cycle 1, rsp_valid no earlier than cycle 3.
// Backpressure: req_ready only in IDLE; rsp_valid is a one-cycle pulse with no backpressure.
//
// Ports: clk/rstn; req_* request (valid/ready, we, addr, wdata, wstrb, is_instr);
//        rsp_* response (valid pulse, rdata, err, exc); m_axi_ar/r/aw/w/b* AXI-Lite master;
//        m_is_instr, m_throw_exception, m_exception_vec MMU sideband.
// Build option: define BIU_TIMEOUT_EN to abort transactions after TIMEOUT_CYC cycles.
// DATA_W must be 32 or 64.
module axi_lite_biu
  import biu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rstn,
  // core request / response
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  input  logic                req_is_instr,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic [2:0]          rsp_exc,
  // AXI-Lite read channels
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  // AXI-Lite write channels
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  // MMU sideband
  output logic                m_is_instr,
  input  logic                m_throw_exception,
  input  logic [2:0]          m_exception_vec
);

  biu_state_e state;
  logic       tmo_expire;
  logic       aw_done;
  logic       w_done;

  assign req_ready = (state == ST_IDLE);

  // A write channel counts as done once its valid has dropped (earlier
  // handshake) or it handshakes this cycle.
  assign aw_done = !m_axi_awvalid || m_axi_awready;
  assign w_done  = !m_axi_wvalid  || m_axi_wready;

`ifdef BIU_TIMEOUT_EN
  logic tmo_en;
  assign tmo_en = (state != ST_IDLE) && (state != ST_RESP);

  biu_timeout #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (req_valid && req_ready),
    .en     (tmo_en),
    .expire (tmo_expire)
  );
`else
  // No watchdog: constant 0 (the comparison only keeps TIMEOUT_CYC referenced).
  assign tmo_expire = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      m_axi_araddr  <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_is_instr    <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
      rsp_exc       <= EXC_NONE;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            m_is_instr <= req_is_instr;
            if (req_we) begin
              m_axi_awaddr  <= req_addr;
              m_axi_wdata   <= req_wdata;
              m_axi_wstrb   <= req_wstrb;
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= ST_WR_ADDR;
            end else begin
              m_axi_araddr  <= req_addr;
              m_axi_arvalid <= 1'b1;
              state         <= ST_RD_ADDR;
            end
          end
        end

        ST_RD_ADDR: begin
          // MMU rejection beats a same-cycle arready; handshake beats timeout.
          if (m_throw_exception) begin
            m_axi_arvalid <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_err       <= 1'b1;
            rsp_exc       <= m_exception_vec;
            rsp_rdata     <= '0;
            state         <= ST_RESP;
          end else if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= ST_RD_DATA;
          end else if (tmo_expire) begin
            m_axi_arvalid <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_err       <= 1'b1;
            rsp_exc       <= EXC_TIMEOUT;
            rsp_rdata     <= '0;
            state         <= ST_RESP;
          end
        end

        ST_RD_DATA: begin
          if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= m_axi_rdata;
            rsp_err      <= (m_axi_rresp != RESP_OKAY);
            rsp_exc      <= resp_to_exc(m_axi_rresp);
            state        <= ST_RESP;
          end else if (tmo_expire) begin
            m_axi_rready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_err      <= 1'b1;
            rsp_exc      <= EXC_TIMEOUT;
            rsp_rdata    <= '0;
            state        <= ST_RESP;
          end
        end

        ST_WR_ADDR: begin
          if (m_throw_exception) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_err       <= 1'b1;
            rsp_exc       <= m_exception_vec;
            rsp_rdata     <= '0;
            state         <= ST_RESP;
          end else if (aw_done && w_done) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b1;
            state         <= ST_WR_RESP;
          end else if (tmo_expire) begin
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            rsp_valid     <= 1'b1;
            rsp_err       <= 1'b1;
            rsp_exc       <= EXC_TIMEOUT;
            rsp_rdata     <= '0;
            state         <= ST_RESP;
          end else begin
            // Only one channel finished: drop just that valid.
            if (m_axi_awready) m_axi_awvalid <= 1'b0;
            if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
          end
        end

        ST_WR_RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_rdata    <= '0;
            rsp_err      <= (m_axi_bresp != RESP_OKAY);
            rsp_exc      <= resp_to_exc(m_axi_bresp);
            state        <= ST_RESP;
          end else if (tmo_expire) begin
            m_axi_bready <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_err      <= 1'b1;
            rsp_exc      <= EXC_TIMEOUT;
            rsp_rdata    <= '0;
            state        <= ST_RESP;
          end
        end

        ST_RESP: begin
          m_is_instr <= 1'b0;
          state      <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_biu.sv
// Directed table-driven bench for axi_lite_biu with a cycle-accurate AXI-Lite slave.
// Latency: each vector carries its hand-computed acceptance-to-rsp_valid cycle count.
// Backpressure: slave ready/valid timing per vector; MMU fault injected on a chosen cycle.
module tb_axi_lite_biu;
  import biu_pkg::*;

  logic        clk;
  logic        rstn;
  logic        req_valid, req_ready, req_we, req_is_instr;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [2:0]  rsp_exc;
  logic [31:0] m_axi_araddr, m_axi_rdata, m_axi_awaddr, m_axi_wdata;
  logic        m_axi_arvalid, m_axi_arready, m_axi_rvalid, m_axi_rready;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic        m_axi_bvalid, m_axi_bready;
  logic [1:0]  m_axi_rresp, m_axi_bresp;
  logic [3:0]  m_axi_wstrb;
  logic        m_is_instr, m_throw_exception;
  logic [2:0]  m_exception_vec;

  axi_lite_biu #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk (clk), .rstn (rstn),
    .req_valid (req_valid), .req_ready (req_ready), .req_we (req_we),
    .req_addr (req_addr), .req_wdata (req_wdata), .req_wstrb (req_wstrb),
    .req_is_instr (req_is_instr),
    .rsp_valid (rsp_valid), .rsp_rdata (rsp_rdata), .rsp_err (rsp_err), .rsp_exc (rsp_exc),
    .m_axi_araddr (m_axi_araddr), .m_axi_arvalid (m_axi_arvalid), .m_axi_arready (m_axi_arready),
    .m_axi_rdata (m_axi_rdata), .m_axi_rresp (m_axi_rresp), .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rready (m_axi_rready),
    .m_axi_awaddr (m_axi_awaddr), .m_axi_awvalid (m_axi_awvalid), .m_axi_awready (m_axi_awready),
    .m_axi_wdata (m_axi_wdata), .m_axi_wstrb (m_axi_wstrb), .m_axi_wvalid (m_axi_wvalid),
    .m_axi_wready (m_axi_wready),
    .m_axi_bresp (m_axi_bresp), .m_axi_bvalid (m_axi_bvalid), .m_axi_bready (m_axi_bready),
    .m_is_instr (m_is_instr), .m_throw_exception (m_throw_exception),
    .m_exception_vec (m_exception_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave timing fields are absolute cycles after acceptance (0 = never);
  // r_dly / b_dly are extra cycles after the address (and data) handshakes.
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          is_instr;
    int          ar_cyc;
    int          r_dly;
    int          aw_cyc;
    int          w_cyc;
    int          b_dly;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          exc_cyc;
    logic [2:0]  exc_vec;
    int          exp_lat;
    bit          exp_err;
    logic [2:0]  exp_exc;
    bit          chk_rdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input int idx, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", nm, idx, got, exp);
    end
  endtask

  task automatic bus_idle();
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = 2'b00;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    m_throw_exception = 1'b0; m_exception_vec = 3'd0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   c, lat, ar_c, aw_c, w_c;
    bit   ar_hs, aw_hs, w_hs, r_hs, b_hs, bus_bad, proto_bad, instr_bad, issued_exp;
    logic err_s;
    logic [2:0]  exc_s;
    logic [31:0] rd_s;
    lat = 0; ar_c = 0; aw_c = 0; w_c = 0;
    ar_hs = 0; aw_hs = 0; w_hs = 0; r_hs = 0; b_hs = 0;
    bus_bad = 0; proto_bad = 0; instr_bad = 0;
    err_s = 1'b0; exc_s = 3'd0; rd_s = '0;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    req_wstrb = v.wstrb; req_is_instr = v.is_instr;
    @(negedge clk);
    req_valid = 1'b0;
    c = 1;
    while (lat == 0 && c <= 40) begin
      if (m_is_instr !== v.is_instr) instr_bad = 1;
      if ((ar_hs && m_axi_arvalid) || (aw_hs && m_axi_awvalid) || (w_hs && m_axi_wvalid) ||
          (r_hs && m_axi_rready) || (b_hs && m_axi_bready)) proto_bad = 1;
      if (m_axi_arvalid && (m_axi_araddr !== v.addr)) bus_bad = 1;
      if (m_axi_awvalid && (m_axi_awaddr !== v.addr)) bus_bad = 1;
      if (m_axi_wvalid && ((m_axi_wdata !== v.wdata) || (m_axi_wstrb !== v.wstrb))) bus_bad = 1;
      if (rsp_valid) begin
        lat = c; err_s = rsp_err; exc_s = rsp_exc; rd_s = rsp_rdata;
      end else begin
        m_axi_arready = (v.ar_cyc != 0) && (c >= v.ar_cyc);
        m_axi_awready = (v.aw_cyc != 0) && (c >= v.aw_cyc);
        m_axi_wready  = (v.w_cyc  != 0) && (c >= v.w_cyc);
        m_axi_rvalid  = ar_hs && !r_hs && (c >= ar_c + 1 + v.r_dly);
        m_axi_rdata   = v.rdata;
        m_axi_rresp   = v.resp;
        m_axi_bvalid  = aw_hs && w_hs && !b_hs && (c >= ((aw_c > w_c) ? aw_c : w_c) + 1 + v.b_dly);
        m_axi_bresp   = v.resp;
        m_throw_exception = (c == v.exc_cyc);
        m_exception_vec   = (c == v.exc_cyc) ? v.exc_vec : 3'd0;
        if (m_axi_arvalid && m_axi_arready && !ar_hs) begin ar_hs = 1; ar_c = c; end
        if (m_axi_awvalid && m_axi_awready && !aw_hs) begin aw_hs = 1; aw_c = c; end
        if (m_axi_wvalid && m_axi_wready && !w_hs) begin w_hs = 1; w_c = c; end
        if (m_axi_rvalid && m_axi_rready) r_hs = 1;
        if (m_axi_bvalid && m_axi_bready) b_hs = 1;
        @(negedge clk);
        c++;
      end
    end
    bus_idle();
    issued_exp = !v.exp_err || (v.exp_exc == EXC_BUS);
    chk("latency", idx, 64'(lat), 64'(v.exp_lat));
    chk("rsp_err", idx, 64'(err_s), 64'(v.exp_err));
    chk("rsp_exc", idx, 64'(exc_s), 64'(v.exp_exc));
    if (v.chk_rdata) chk("rsp_rdata", idx, 64'(rd_s), 64'(v.exp_rdata));
    chk("bus_issued", idx, 64'(v.we ? b_hs : r_hs), 64'(issued_exp));
    chk("m_is_instr_busy", idx, 64'(instr_bad), 64'd0);
    chk("bus_fields", idx, 64'(bus_bad), 64'd0);
    chk("valid_drop", idx, 64'(proto_bad), 64'd0);
    @(negedge clk);
    chk("post_idle", idx, 64'({rsp_valid, req_ready, m_is_instr}), 64'(3'b010));
  endtask

  initial begin
    bit seen;
    rstn = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    req_is_instr = 1'b0;
    bus_idle();

    //        we addr         wdata        strb  ins ar r  aw w  b  resp   rdata        exc ev    lat err exc  chk exp_rdata
    vecs.push_back('{1'b0, 32'h0000_1000, 32'h0,       4'h0, 1'b0, 1, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 0, 3'd0, 3, 1'b0, 3'd0, 1'b1, 32'hDEAD_BEEF});
    vecs.push_back('{1'b1, 32'h0000_2004, 32'hCAFE_F00D, 4'h3, 1'b0, 0, 0, 1, 3, 0, 2'b00, 32'h0,   0, 3'd0, 5, 1'b0, 3'd0, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_3008, 32'h0,       4'h0, 1'b0, 3, 1, 0, 0, 0, 2'b10, 32'h1234_5678, 0, 3'd0, 6, 1'b1, 3'd5, 1'b1, 32'h1234_5678});
    vecs.push_back('{1'b0, 32'h0000_4000, 32'h0,       4'h0, 1'b1, 1, 0, 0, 0, 0, 2'b00, 32'h5555_5555, 1, 3'd1, 2, 1'b1, 3'd1, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_500C, 32'h1122_3344, 4'h0, 1'b0, 0, 0, 1, 1, 2, 2'b10, 32'h0,   0, 3'd0, 5, 1'b1, 3'd5, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_6010, 32'hA5A5_A5A5, 4'hF, 1'b1, 0, 0, 2, 1, 0, 2'b00, 32'h0,   0, 3'd0, 4, 1'b0, 3'd0, 1'b1, 32'h0});
    vecs.push_back('{1'b1, 32'h0000_7000, 32'h0000_0001, 4'h1, 1'b0, 0, 0, 1, 0, 0, 2'b00, 32'h0,   2, 3'd7, 3, 1'b1, 3'd7, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_8000, 32'h0,       4'h0, 1'b0, 0, 0, 0, 0, 0, 2'b00, 32'h0,     3, 3'd2, 4, 1'b1, 3'd2, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h0000_9000, 32'h0,       4'h0, 1'b1, 2, 0, 0, 0, 0, 2'b00, 32'h0F0F_0F0F, 0, 3'd0, 4, 1'b0, 3'd0, 1'b1, 32'h0F0F_0F0F});
`ifdef BIU_TIMEOUT_EN
    // arready never comes: arvalid holds for 15 cycles, response in cycle 16.
    vecs.push_back('{1'b0, 32'h0000_B000, 32'h0,       4'h0, 1'b0, 0, 0, 0, 0, 0, 2'b00, 32'h0,     0, 3'd0, 16, 1'b1, 3'd6, 1'b0, 32'h0});
`endif

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst_ctl", 0, 64'({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready, m_axi_bready,
                          rsp_valid, rsp_err, rsp_exc, m_is_instr}), 64'd0);
    chk("rst_addr", 0, {m_axi_araddr, m_axi_awaddr}, 64'd0);
    chk("rst_data", 0, {m_axi_wdata, rsp_rdata}, 64'd0);
    chk("rst_wstrb", 0, 64'(m_axi_wstrb), 64'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 0, 64'(req_ready), 64'd1);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset while waiting for the write response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_A000; req_wdata = 32'h0BAD_CAFE;
    req_wstrb = 4'hF; req_is_instr = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; m_axi_awready = 1'b1; m_axi_wready = 1'b1;
    @(negedge clk);
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    chk("mid_bready", 0, 64'(m_axi_bready), 64'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_outputs", 0, 64'({m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready,
                                  m_axi_bready, rsp_valid, m_is_instr}), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("mid_rst_no_rsp", 0, 64'(seen), 64'd0);
    chk("mid_rst_req_ready", 0, 64'(req_ready), 64'd1);

    // Normal operation resumes after the mid-transaction reset.
    run_vec(vecs[0], 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
